shared_imem_arbiter: RTL
========================

# shared_imem_arbiter

Parametrised N-port front end that lets several single-cycle CPU cores share one synchronous-read instruction memory. Each cycle it grants at most one requesting core with round-robin fairness and an optional burst-hold mode, drives the granted core's address to memory, and returns the read data one cycle later with a per-port valid. Non-granted cores see `gnt` low and must stall their PC. The block sits between the CPU instances and the single instruction ROM.

## Interface
Parameters:
- `N_PORTS`, 3: number of requesting cores (2..16).
- `ADDR_W`, 6: instruction memory word-address width.
- `DATA_W`, 32: instruction width.
- `MAX_BURST`, 1: maximum consecutive grants to one port while others wait (1 = pure round-robin).

Ports:
- `clk`  in  1: clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  N_PORTS: per-port fetch request.
- `addr`  in  N_PORTS×ADDR_W: per-port fetch word address, unpacked array `[N_PORTS]`.
- `gnt`  out  N_PORTS: one-hot or zero; request of port i accepted this cycle.
- `rvalid`  out  N_PORTS: one-hot or zero; `rdata` belongs to port i this cycle.
- `rdata`  out  DATA_W: returned instruction, shared by all ports.
- `mem_en`  out  1: memory read enable.
- `mem_addr`  out  ADDR_W: memory read address.
- `mem_rdata`  in  DATA_W: memory data, valid the cycle after `mem_en`.

## Operation
- Accept = `req[i] & gnt[i]`. `gnt` is combinational from `req` and registered state. A port with `req` low is never granted.
- `mem_en` = OR of `gnt`; `mem_addr` = `addr` of granted port, else 0.
- Registered state: `owner` (last granted index, `$clog2(N_PORTS)` bits), `burst_cnt` (`$clog2(MAX_BURST+1)` bits), `resp_valid`, `resp_id`.
- Arbitration each cycle:
  - HOLD: if `req[owner]` and `burst_cnt < MAX_BURST`, grant `owner`.
  - else ROTATE: grant first requester scanning `owner+1, owner+2, …` modulo `N_PORTS`, wrapping; owner itself checked last.
  - If the only requester is `owner`, it is granted regardless of `burst_cnt` (no idle cycle while work is pending).
- On a grant to port g: `owner <= g`; `burst_cnt <= (g == owner) ? sat(burst_cnt+1) : 1`. Grant to owner beyond the cap with no competitor keeps `burst_cnt` saturated at `MAX_BURST`.
- No grant: `owner` held, `burst_cnt <= 0`.
- Response: `resp_valid <= |gnt`, `resp_id <= g`. `rvalid = resp_valid ? onehot(resp_id) : 0`; `rdata = mem_rdata` (pass-through, no extra register).
- Address is not checked; out-of-range wraps naturally in `ADDR_W` bits.

## Timing
- Reset values: `owner = N_PORTS-1` (port 0 wins first), `burst_cnt = 0`, `resp_valid = 0`, `rvalid = 0`. `gnt`, `mem_en`, `mem_addr` follow `req` combinationally even in reset's deassert cycle; while `rst` is high `gnt = 0`, `mem_en = 0`.
- Grant latency 0 cycles (same cycle as `req`); data latency exactly 1 cycle after accept.
- Throughput: one fetch per cycle total, back-to-back, no bubbles.
- Worst-case wait for a requesting port: `(N_PORTS-1)×MAX_BURST` cycles.
- Port dropping `req` in the cycle after grant still receives its `rvalid`.
- Reset asserted mid-operation: pending response discarded, `rvalid` low immediately (async).

## Structure
- Package `shared_imem_pkg`: `port_idx_t` width helper function, `onehot` function, default parameter constants.
- Sub-module `imem_rr_arbiter` (req, owner, burst_cnt → gnt, grant index, grant valid; purely combinational), instanced once; state and response pipe stay in the top.

## Test plan
- Reset, then `req=3'b111`, `MAX_BURST=1`: grants cycle 0→1→2→0…, `rvalid` follows one cycle later with matching `mem_rdata`.
- `req=3'b010` only, addr 5: `gnt=010` every cycle, `mem_addr=5`, `rvalid=010` from next cycle continuously.
- `MAX_BURST=4`, all requesting: port 0 granted 4 cycles, then port 1 ×4, then port 2 ×4; no port waits more than 8 cycles.
- Port 2 granted, then `req=3'b100` stays alone past cap: remains granted, no bubble; port 0 raises `req` → granted next cycle.
- `req=0` for one cycle between grants: `mem_en=0`, `rvalid=0` next cycle, `owner` unchanged (rotation resumes after it).
- Assert `rst` in cycle after an accept: `rvalid` drops immediately; after release port 0 granted first.

Source files
------------

// File: rtl/shared_imem_pkg.sv
// Shared definitions for the multi-core instruction memory front end.
package shared_imem_pkg;

  localparam int DEF_N_PORTS   = 3;
  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 1;

  // Widest port count supported; sizes the onehot helper.
  localparam int MAX_PORTS = 16;

  // Width of a port index (port_idx_t); at least one bit even for tiny configs.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot decode of a port index; callers truncate to their port count.
  function automatic logic [MAX_PORTS-1:0] onehot(input logic [3:0] idx);
    logic [MAX_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/imem_rr_arbiter.sv
// Combinational round-robin arbiter with optional burst hold for the current owner.
module imem_rr_arbiter
  import shared_imem_pkg::*;
#(
  parameter int N_PORTS   = DEF_N_PORTS,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int IDX_W     = idxWidth(DEF_N_PORTS),
  parameter int CNT_W     = $clog2(DEF_MAX_BURST + 1)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   owner,
  input  logic [CNT_W-1:0]   burstCnt,
  output logic [N_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]   gntIdx,
  output logic               gntValid
);

  logic             holdOk;
  logic [IDX_W-1:0] cand;

  // Hold the owner while its burst is live; otherwise scan owner+1.. with owner last.
  // A zero burst count means no burst is in progress (after reset or an idle
  // cycle), so rotation applies and the port after the owner gets first chance.
  always_comb begin
    gnt      = '0;
    gntIdx   = '0;
    gntValid = 1'b0;
    cand     = '0;
    holdOk   = req[owner] && (burstCnt != '0) && (burstCnt < CNT_W'(MAX_BURST));
    if (holdOk) begin
      gntIdx   = owner;
      gntValid = 1'b1;
    end else begin
      for (int k = 1; k <= N_PORTS; k++) begin
        cand = IDX_W'((int'(owner) + k) % N_PORTS);
        if (!gntValid && req[cand]) begin
          gntIdx   = cand;
          gntValid = 1'b1;
        end
      end
    end
    if (gntValid) begin
      gnt[gntIdx] = 1'b1;
    end
  end

endmodule

// File: rtl/shared_imem_arbiter.sv
// N-port front end sharing one synchronous-read instruction memory among cores.
//
// Handshake: a core holds req high with its addr; gnt[i] high in the same cycle
// means the fetch is accepted (req[i] & gnt[i]). A core seeing gnt low must stall
// and keep requesting. Exactly one cycle after an accept, rvalid[i] is high and
// rdata carries the instruction, whether or not the core still requests.
module shared_imem_arbiter
  import shared_imem_pkg::*;
#(
  parameter int N_PORTS   = DEF_N_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic [ADDR_W-1:0]  addr [N_PORTS],
  output logic [N_PORTS-1:0] gnt,
  output logic [N_PORTS-1:0] rvalid,
  output logic [DATA_W-1:0]  rdata,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int IDX_W = idxWidth(N_PORTS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   burstCnt;
  logic               respValid;
  logic [IDX_W-1:0]   respId;
  logic [N_PORTS-1:0] arbGnt;
  logic [IDX_W-1:0]   arbIdx;
  logic               arbValid;
  logic               accept;

  imem_rr_arbiter #(
    .N_PORTS  (N_PORTS),
    .MAX_BURST(MAX_BURST),
    .IDX_W    (IDX_W),
    .CNT_W    (CNT_W)
  ) uArb (
    .req     (req),
    .owner   (owner),
    .burstCnt(burstCnt),
    .gnt     (arbGnt),
    .gntIdx  (arbIdx),
    .gntValid(arbValid)
  );

  // Grants are suppressed while reset is held so nothing reaches memory.
  assign accept   = arbValid & ~rst;
  assign gnt      = accept ? arbGnt : '0;
  assign mem_en   = accept;
  assign mem_addr = accept ? addr[arbIdx] : '0;

  // Response is the memory output directly; only the owner tag is pipelined.
  assign rdata  = mem_rdata;
  assign rvalid = respValid ? N_PORTS'(onehot(4'(respId))) : '0;

  // Arbitration state and one-deep response tag, updated on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= IDX_W'(N_PORTS - 1);
      burstCnt  <= '0;
      respValid <= 1'b0;
      respId    <= '0;
    end else if (arbValid) begin
      owner     <= arbIdx;
      respValid <= 1'b1;
      respId    <= arbIdx;
      if (arbIdx == owner) begin
        burstCnt <= (burstCnt >= CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST)
                                                     : burstCnt + CNT_W'(1);
      end else begin
        burstCnt <= CNT_W'(1);
      end
    end else begin
      burstCnt  <= '0;
      respValid <= 1'b0;
    end
  end

endmodule
